// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmit stage: streams frame bytes to the PCS, zero-pads short
// frames, appends the CRC-32 FCS and enforces the inter-frame gap.
module eth_mac_tx #(
    parameter int MIN_DATA_BYTES = 60,
    parameter int IFG_CYCLES     = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_eof,
    input  logic        tx_pause,
    output logic        underrun,
    output logic [15:0] frames_sent
);

    typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, IFG} state_t;

    localparam logic [11:0] MIN_W    = 12'(MIN_DATA_BYTES);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_eof_q, tx_eof_d;
    logic        underrun_q, underrun_d;
    logic [15:0] frames_q, frames_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [15:0] ifg_cnt_q, ifg_cnt_d;
    logic        ifg_run_q, ifg_run_d;

    logic        load_en;
    logic        accept;
    logic [10:0] cnt_inc;
    logic [11:0] cnt_wide;
    logic        short_frame;
    logic [31:0] fcs;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign load_en     = ~tx_valid_q | ~tx_pause;
    assign s_ready     = ~reset & load_en & ((state_q == IDLE) | (state_q == DATA));
    assign accept      = s_valid & s_ready;
    assign cnt_inc     = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    // Unsaturated count-after-load, so the pad decision never wraps.
    assign cnt_wide    = {1'b0, cnt_q} + 12'd1;
    assign short_frame = cnt_wide < MIN_W;
    assign fcs         = ~crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_eof_q   <= 1'b0;
            underrun_q <= 1'b0;
            frames_q   <= 16'h0000;
            crc_q      <= 32'hFFFFFFFF;
            cnt_q      <= 11'd0;
            fcs_idx_q  <= 2'd0;
            ifg_cnt_q  <= 16'd0;
            ifg_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_eof_q   <= tx_eof_d;
            underrun_q <= underrun_d;
            frames_q   <= frames_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            fcs_idx_q  <= fcs_idx_d;
            ifg_cnt_q  <= ifg_cnt_d;
            ifg_run_q  <= ifg_run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_eof_d   = tx_eof_q;
        underrun_d = 1'b0;
        frames_d   = frames_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        fcs_idx_d  = fcs_idx_q;
        ifg_cnt_d  = ifg_cnt_q;
        ifg_run_d  = ifg_run_q;

        if (load_en) begin
            tx_valid_d = 1'b0;
            tx_eof_d   = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = s_data;
                    crc_d      = crc_next(crc_q, s_data);
                    cnt_d      = cnt_inc;
                    state_d    = DATA;
                    if (s_last) begin
                        state_d   = short_frame ? PAD : FCS;
                        fcs_idx_d = 2'd0;
                    end
                end else if ((state_q == DATA) && load_en && !s_valid) begin
                    underrun_d = 1'b1;
                end
            end
            PAD: begin
                if (load_en) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'h00;
                    crc_d      = crc_next(crc_q, 8'h00);
                    cnt_d      = cnt_inc;
                    if (!short_frame) begin
                        state_d   = FCS;
                        fcs_idx_d = 2'd0;
                    end
                end
            end
            FCS: begin
                if (load_en) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'(fcs >> {fcs_idx_q, 3'b000});
                    fcs_idx_d  = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        tx_eof_d  = 1'b1;
                        state_d   = IFG;
                        ifg_run_d = 1'b0;
                    end
                end
            end
            IFG: begin
                // The gap starts at the eof handshake, not at the eof load.
                if (!ifg_run_q) begin
                    if (tx_valid_q && tx_eof_q && !tx_pause) begin
                        frames_d  = frames_q + 16'd1;
                        ifg_cnt_d = 16'd0;
                        if (IFG_CYCLES == 0) begin
                            state_d = IDLE;
                            crc_d   = 32'hFFFFFFFF;
                            cnt_d   = 11'd0;
                        end else begin
                            ifg_run_d = 1'b1;
                        end
                    end
                end else if (ifg_cnt_q == IFG_LAST) begin
                    state_d   = IDLE;
                    crc_d     = 32'hFFFFFFFF;
                    cnt_d     = 11'd0;
                    ifg_run_d = 1'b0;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_eof      = tx_eof_q;
    assign underrun    = underrun_q;
    assign frames_sent = frames_q;

endmodule
